// File: rtl/fifo_pkg.sv
// fifo_pkg: shared word type and limits for the FIFO read-side blocks
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_READ_LATENCY = 4;
  typedef logic [DATA_WIDTH-1:0] fifo_word_t;
endpackage

// File: rtl/fwft_skid_buf.sv
// fwft_skid_buf: small circular buffer presenting its head word as registered state
module fwft_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [CW-1:0]         count
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid = (count != '0);
  assign data = mem[rd_ptr];

  // storage, pointers and occupancy; clr empties the buffer but keeps stored words
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (pop) rd_ptr <= wrap_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && count == '0));
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a fixed-latency FIFO read port into a first-word-fall-through valid/ready stream
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int READ_LATENCY = 1,
  parameter int BUF_DEPTH = READ_LATENCY + 1,
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CW-1:0]         occupancy
);
  logic [READ_LATENCY-1:0] in_flight;
  logic pop, ret;
  logic [CW:0] demand;

  assign pop = m_valid && m_ready;
  assign ret = in_flight[READ_LATENCY-1];
  // slots already promised: buffered words that stay plus reads still travelling
  assign demand = {1'b0, occupancy} - (CW + 1)'(pop) + (CW + 1)'($countones(in_flight));
  // the strobe is held low while reset is asserted so the FIFO is never popped then
  assign fifo_rd_en = rst && !fifo_empty && !flush && (demand < (CW + 1)'(BUF_DEPTH));

  // one bit per issued read, shifted until its data appears on fifo_data; flush drops them all
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_flight <= '0;
    else in_flight <= flush ? '0 : (in_flight << 1) | READ_LATENCY'(fifo_rd_en);
  end

  fwft_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .push(ret),
    .push_data(fifo_data),
    .pop(pop),
    .valid(m_valid),
    .data(m_data),
    .count(occupancy)
  );

  a_no_read_when_empty: assert property (@(posedge clk) disable iff (!rst) !(fifo_rd_en && fifo_empty));
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed and soak checks of the stream reader at read latency 1 and 2
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [2], fifo_empty [2], rd_en [2], flush [2], m_valid [2], m_ready [2], hold_ne [2];
  fifo_word_t fifo_data [2], m_data [2];
  logic [1:0] occ [2];

  fifo_word_t q [2][$];
  fifo_word_t rx [2][$];
  fifo_word_t expq [2][$];
  int rxc [2][$];
  fifo_word_t dq [2][4];
  fifo_word_t popped [2], sd [2], pd [2], seq [2];
  logic srd [2], sv [2], pv [2], pp [2], pf [2], done [2];
  logic [1:0] socc [2];
  int cyc [2], rdc [2], first_rd [2], first_v [2], v_empty [2], v_occ [2], v_hold [2];
  int total = 0, bad = 0;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    fifo_stream_reader #(.DATA_WIDTH(8), .READ_LATENCY(g + 1)) dut (
      .clk(clk),
      .rst(rst[g]),
      .fifo_empty(fifo_empty[g]),
      .fifo_rd_en(rd_en[g]),
      .fifo_data(fifo_data[g]),
      .flush(flush[g]),
      .m_valid(m_valid[g]),
      .m_ready(m_ready[g]),
      .m_data(m_data[g]),
      .occupancy(occ[g])
    );
    initial run(g);
  end

  task automatic chk(input string tag, input int ln, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL lat%0d %s: got %0h expected %0h", ln + 1, tag, got, exp);
    end
  endtask

  task automatic put(input int ln, input fifo_word_t w);
    q[ln].push_back(w);
    fifo_empty[ln] = 1'b0;
  endtask

  task automatic clr(input int ln);
    rx[ln].delete();
    rxc[ln].delete();
    rdc[ln] = 0;
    first_rd[ln] = -1;
    first_v[ln] = -1;
  endtask

  // samples the current cycle just before the edge, models the FIFO, then moves to the next cycle
  task automatic step(input int ln);
    #1;
    srd[ln] = rd_en[ln];
    sv[ln] = m_valid[ln];
    sd[ln] = m_data[ln];
    socc[ln] = occ[ln];
    if (rd_en[ln]) begin
      rdc[ln]++;
      if (first_rd[ln] < 0) first_rd[ln] = cyc[ln];
      if (fifo_empty[ln] || q[ln].size() == 0) v_empty[ln]++;
      else popped[ln] = q[ln].pop_front();
    end
    if (m_valid[ln] && first_v[ln] < 0) first_v[ln] = cyc[ln];
    if (m_valid[ln] && m_ready[ln]) begin
      rx[ln].push_back(m_data[ln]);
      rxc[ln].push_back(cyc[ln]);
    end
    if (int'(occ[ln]) > ln + 2) v_occ[ln]++;
    if (pv[ln] && !pp[ln] && !pf[ln] && (!m_valid[ln] || m_data[ln] != pd[ln])) v_hold[ln]++;
    pv[ln] = m_valid[ln];
    pd[ln] = m_data[ln];
    pp[ln] = m_valid[ln] && m_ready[ln];
    pf[ln] = flush[ln] || !rst[ln];
    @(negedge clk);
    cyc[ln]++;
    for (int i = 3; i > 0; i--) dq[ln][i] = dq[ln][i - 1];
    dq[ln][0] = popped[ln];
    fifo_data[ln] = dq[ln][ln];
    fifo_empty[ln] = hold_ne[ln] ? 1'b0 : (q[ln].size() == 0);
  endtask

  task automatic run(input int ln);
    int d = ln + 2;
    int l = ln + 1;
    rst[ln] = 1'b1;
    flush[ln] = 1'b0;
    m_ready[ln] = 1'b1;
    hold_ne[ln] = 1'b1;
    fifo_empty[ln] = 1'b0;
    fifo_data[ln] = '0;
    popped[ln] = '0;
    for (int i = 0; i < 4; i++) dq[ln][i] = '0;
    pv[ln] = 1'b0;
    pp[ln] = 1'b0;
    pf[ln] = 1'b1;
    cyc[ln] = 0;
    v_empty[ln] = 0;
    v_occ[ln] = 0;
    v_hold[ln] = 0;
    seq[ln] = '0;
    done[ln] = 1'b0;
    clr(ln);
    @(negedge clk);
    rst[ln] = 1'b0;
    repeat (3) begin
      step(ln);
      chk("reset_rd_en", ln, srd[ln], 0);
      chk("reset_m_valid", ln, sv[ln], 0);
      chk("reset_m_data", ln, sd[ln], 0);
      chk("reset_occupancy", ln, socc[ln], 0);
    end
    rst[ln] = 1'b1;
    hold_ne[ln] = 1'b0;
    fifo_empty[ln] = 1'b1;

    clr(ln);
    for (int i = 1; i <= 4; i++) put(ln, fifo_word_t'(8'h11 * i));
    repeat (12) step(ln);
    chk("stream_latency", ln, first_v[ln] - first_rd[ln], l + 1);
    chk("stream_count", ln, rx[ln].size(), 4);
    for (int i = 0; i < 4; i++) chk("stream_word", ln, rx[ln][i], 8'h11 * (i + 1));
    chk("stream_no_bubble", ln, rxc[ln][3] - rxc[ln][0], 3);

    clr(ln);
    m_ready[ln] = 1'b0;
    for (int i = 0; i < 6; i++) put(ln, fifo_word_t'(8'hA0 + i));
    repeat (10) step(ln);
    chk("bp_rd_pulses", ln, rdc[ln], d);
    chk("bp_occupancy", ln, socc[ln], d);
    chk("bp_head_data", ln, sd[ln], 8'hA0);
    chk("bp_head_valid", ln, sv[ln], 1);
    m_ready[ln] = 1'b1;
    repeat (14) step(ln);
    chk("bp_count", ln, rx[ln].size(), 6);
    for (int i = 0; i < 6; i++) chk("bp_word", ln, rx[ln][i], 8'hA0 + i);

    clr(ln);
    put(ln, 8'h5C);
    repeat (8) step(ln);
    chk("empty_rd_pulses", ln, rdc[ln], 1);
    chk("empty_count", ln, rx[ln].size(), 1);
    chk("empty_word", ln, rx[ln][0], 8'h5C);
    chk("empty_valid_after", ln, sv[ln], 0);

    clr(ln);
    put(ln, 8'h77);
    put(ln, 8'h88);
    step(ln);
    chk("flush_issue", ln, srd[ln], 1);
    flush[ln] = 1'b1;
    step(ln);
    chk("flush_no_rd", ln, srd[ln], 0);
    flush[ln] = 1'b0;
    step(ln);
    chk("flush_valid_off", ln, sv[ln], 0);
    chk("flush_occupancy", ln, socc[ln], 0);
    repeat (8) step(ln);
    chk("flush_count", ln, rx[ln].size(), 1);
    chk("flush_next_word", ln, rx[ln][0], 8'h88);

    clr(ln);
    expq[ln].delete();
    for (int c = 0; c < 320; c++) begin
      m_ready[ln] = ($urandom % 4) != 0;
      if ($urandom % 2 == 1) begin
        put(ln, seq[ln]);
        expq[ln].push_back(seq[ln]);
        seq[ln]++;
      end
      step(ln);
    end
    m_ready[ln] = 1'b1;
    repeat (60) step(ln);
    chk("soak_count", ln, rx[ln].size(), expq[ln].size());
    for (int i = 0; i < expq[ln].size(); i++) chk("soak_word", ln, rx[ln][i], expq[ln][i]);
    chk("rd_while_empty", ln, v_empty[ln], 0);
    chk("occupancy_over_depth", ln, v_occ[ln], 0);
    chk("head_not_held", ln, v_hold[ln], 0);
    done[ln] = 1'b1;
  endtask

  initial begin
    wait (done[0] === 1'b1 && done[1] === 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: lanes did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
